branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Writer-side companion to the branch history cache. Records each predicted branch in order and matches it against the branch's resolved outcome from execute.
- Produces the cache update write (update pc, taken, write enable).
- Flags mispredictions, supplies the redirect PC and flushes younger in-flight predictions.
- Sits between fetch/predict and execute.

Parameters:
- DEPTH, 4, in-flight branch entries; power of 2, at least 2.
- PC_WIDTH, 10, program counter width; must match the cache pc width.
- RECOVER_CYCLES, 2, cycles predictions are blocked after a mispredict; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- pred_valid  in  1  fetch presents a predicted branch.
- pred_ready  out  1  queue accepts a prediction this cycle.
- pred_pc  in  PC_WIDTH  PC of the predicted branch.
- pred_taken  in  1  predicted direction.
- pred_target  in  PC_WIDTH  predicted target, used only when pred_taken=1.
- res_valid  in  1  execute resolves the oldest outstanding branch.
- res_taken  in  1  actual direction.
- res_target  in  PC_WIDTH  actual target.
- upd_we  out  1  one-cycle write strobe to the history cache.
- upd_pc  out  PC_WIDTH  PC of the resolved branch.
- upd_taken  out  1  actual direction, shifted into the cache history.
- mispredict  out  1  one-cycle pulse, aligned with upd_we.
- redirect_pc  out  PC_WIDTH  correct next PC, valid while mispredict=1.
- res_err  out  1  one-cycle pulse: resolve arrived with the queue empty.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
Reset and state:
- Reset is asynchronous and active-high. All outputs, pointers and count go to 0; the FSM goes to RUN.
- Release of reset is synchronous to clk.
- Reset mid-recovery or mid-queue discards everything.

Storage and enqueue:
- Circular FIFO of {pc, pred_taken, pred_target}. Head and tail pointers wrap mod DEPTH.
- pred_ready = (state==RUN) && (count<DEPTH). It is registered-state based only, with no combinational path from res_valid.
- Enqueue occurs when pred_valid && pred_ready at the rising edge.

Resolve:
- Resolve occurs when res_valid && count>0 && state==RUN. It pops the head.
- Outputs are registered with 1-cycle latency. The cycle after the resolve edge:
  - upd_we=1
  - upd_pc=head.pc
  - upd_taken=res_taken
- Mispredict condition: (res_taken != head.pred_taken) || (res_taken && res_target != head.pred_target).
- When it holds:
  - mispredict=1 in the same cycle as upd_we.
  - redirect_pc = res_taken ? res_target : head.pc+1, modulo 2^PC_WIDTH, so 0x3FF+1 wraps to 0x000.
- When it does not hold, mispredict=0 and redirect_pc holds its previous value.
- res_valid with count==0 in RUN: no pop and no upd_we; res_err pulses next cycle.
- res_valid in RECOVER is ignored silently.

Simultaneous events:
- Enqueue and resolve in the same cycle: both take effect and count is unchanged.
- An entry enqueued this cycle cannot be resolved this cycle; there is no bypass.

Flush on mispredict:
- At the resolve edge where the mispredict condition holds:
  - all remaining entries are discarded, count=0 and head=tail;
  - any same-cycle enqueue is dropped, since flush wins.
- The FSM then goes RUN -> RECOVER and loads a down-counter with RECOVER_CYCLES.
- In RECOVER, pred_ready=0. The counter decrements each cycle and the FSM returns to RUN when it reaches 1.
- pred_ready is therefore low for exactly RECOVER_CYCLES cycles, starting the cycle after the mispredict edge.

Output timing:
- upd_we, mispredict and res_err are single-cycle pulses, low otherwise.
- upd_pc and upd_taken hold their last values between updates.

Test Plan:
1. Reset then idle: rst=1 asynchronously mid-cycle -> all outputs 0, count=0, pred_ready=1 after release.
2. Correct prediction: enqueue pc=0x012 taken target=0x040, then resolve taken target=0x040 -> next cycle upd_we=1, upd_pc=0x012, upd_taken=1, mispredict=0, count=0.
3. Direction mispredict with flush: enqueue pc 0x010/0x020/0x030 (not taken), then resolve res_taken=1 target=0x100 -> mispredict=1, redirect_pc=0x100, count=0; pred_ready low exactly 2 cycles, and a res_valid during those cycles produces no upd_we.
4. Not-taken redirect wrap: enqueue pc=0x3FF predicted taken target=0x000, resolve not taken -> mispredict=1, redirect_pc=0x000.
5. Full queue: enqueue 4 entries -> pred_ready=0, count=4; a 5th pred_valid is not accepted; simultaneous resolve+enqueue at count=3 keeps count=3 and FIFO order is preserved over 6 further resolves.
6. Underflow: res_valid with count=0 -> res_err pulses one cycle, upd_we stays 0, state stays RUN.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch prediction queue with resolve, update and mispredict flush
module branch_resolve_queue #(
  parameter int DEPTH          = 4,
  parameter int PC_WIDTH       = 10,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  output logic                       pred_ready,
  input  logic [PC_WIDTH-1:0]        pred_pc,
  input  logic                       pred_taken,
  input  logic [PC_WIDTH-1:0]        pred_target,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [PC_WIDTH-1:0]        res_target,
  output logic                       upd_we,
  output logic [PC_WIDTH-1:0]        upd_pc,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   rec_cnt, rec_cnt_nx;
  logic [AW-1:0]   head, tail;

  logic [PC_WIDTH-1:0] mem_pc     [DEPTH];
  logic                mem_taken  [DEPTH];
  logic [PC_WIDTH-1:0] mem_target [DEPTH];

  logic                do_enq, do_res, mis, flush;
  logic [PC_WIDTH-1:0] head_pc, head_target;
  logic                head_taken;

  assign pred_ready  = (state == RUN) && (count < FULL);
  assign do_enq      = pred_valid && pred_ready;
  assign do_res      = res_valid && (count != '0) && (state == RUN);
  assign head_pc     = mem_pc[head];
  assign head_taken  = mem_taken[head];
  assign head_target = mem_target[head];
  // Target only matters when the branch really was taken.
  assign mis   = (res_taken != head_taken) || (res_taken && (res_target != head_target));
  assign flush = do_res && mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      rec_cnt <= '0;
    end else begin
      state   <= state_nx;
      rec_cnt <= rec_cnt_nx;
    end
  end

  // Recovery window holds pred_ready low for exactly RECOVER_CYCLES cycles.
  always_comb begin
    state_nx   = state;
    rec_cnt_nx = rec_cnt;
    case (state)
      RUN: begin
        if (flush) begin
          state_nx   = RECOVER;
          rec_cnt_nx = RW'(RECOVER_CYCLES);
        end
      end
      RECOVER: begin
        if (rec_cnt == RW'(1)) state_nx = RUN;
        else rec_cnt_nx = rec_cnt - RW'(1);
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_pc[tail]     <= pred_pc;
      mem_taken[tail]  <= pred_taken;
      mem_target[tail] <= pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_we      <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      res_err     <= 1'b0;
    end else begin
      upd_we     <= do_res;
      mispredict <= flush;
      res_err    <= res_valid && (count == '0) && (state == RUN);
      if (do_res) begin
        upd_pc    <= head_pc;
        upd_taken <= res_taken;
      end
      if (flush) begin
        redirect_pc <= res_taken ? res_target : head_pc + PC_WIDTH'(1);
        // Flush wins over a same-cycle enqueue: tail stays put.
        head  <= tail;
        count <= '0;
      end else begin
        if (do_enq) tail <= tail + AW'(1);
        if (do_res) head <= head + AW'(1);
        case ({do_enq, do_res})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - vector table, corner sequences and random model check for branch_resolve_queue
module tb_branch_resolve_queue;

  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid, pred_taken, res_valid, res_taken;
  logic [9:0] pred_pc, pred_target, res_target;
  logic       pred_ready, upd_we, upd_taken, mispredict, res_err;
  logic [9:0] upd_pc, redirect_pc;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .PC_WIDTH(10), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_we(upd_we), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .res_err(res_err), .count(count)
  );

  typedef struct {
    logic pv; logic [9:0] ppc; logic pt; logic [9:0] ptg;
    logic rv; logic rt; logic [9:0] rtg;
    logic we; logic [9:0] upc; logic ut; logic mis; logic [9:0] rpc;
    logic err; logic [2:0] cnt; logic rdy;
  } vec_t;

  typedef struct { logic [9:0] pc; logic t; logic [9:0] tg; } ent_t;

  vec_t tbl[19];
  ent_t mq[$];
  int   blocked;
  logic [9:0] m_upc, m_rpc;
  logic       m_ut;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic pv, input logic [9:0] ppc, input logic pt, input logic [9:0] ptg,
                       input logic rv, input logic rt, input logic [9:0] rtg);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
  endtask

  task automatic model_reset();
    mq.delete(); blocked = 0; m_upc = '0; m_rpc = '0; m_ut = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle against the queue-based reference model.
  task automatic step(input logic pv, input logic [9:0] ppc, input logic pt, input logic [9:0] ptg,
                      input logic rv, input logic rt, input logic [9:0] rtg);
    logic exp_rdy, res_ok, exp_err, mis;
    ent_t h, e;
    drive(pv, ppc, pt, ptg, rv, rt, rtg);
    #2;
    exp_rdy = (blocked == 0) && (mq.size() < 4);
    chk("pred_ready", 32'(pred_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    res_ok  = rv && (mq.size() > 0) && (blocked == 0);
    exp_err = rv && (mq.size() == 0) && (blocked == 0);
    mis = 1'b0;
    if (blocked > 0) blocked--;
    if (res_ok) begin
      h = mq[0];
      m_upc = h.pc;
      m_ut = rt;
      mis = (rt != h.t) || (rt && (rtg != h.tg));
      if (mis) begin
        m_rpc = rt ? rtg : h.pc + 10'd1;
        mq.delete();
        blocked = RC;
      end else begin
        void'(mq.pop_front());
      end
    end
    if (exp_rdy && pv && !mis) begin
      e.pc = ppc; e.t = pt; e.tg = ptg;
      mq.push_back(e);
    end
    chk("upd_we", 32'(upd_we), 32'(res_ok));
    chk("upd_pc", 32'(upd_pc), 32'(m_upc));
    chk("upd_taken", 32'(upd_taken), 32'(m_ut));
    chk("mispredict", 32'(mispredict), 32'(mis));
    chk("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    chk("res_err", 32'(res_err), 32'(exp_err));
    chk("count", 32'(count), 32'(mq.size()));
  endtask

  task automatic step_resolve_ok(input logic pv, input logic [9:0] ppc);
    logic rt;
    logic [9:0] rtg;
    rt  = mq[0].t;
    rtg = mq[0].tg;
    step(pv, ppc, 1'b0, 10'h000, 1'b1, rt, rtg);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //                pv    ppc      pt    ptg      rv    rt    rtg       we    upc      ut    mis   rpc      err   cnt    rdy
    tbl[0]  = '{1'b1, 10'h012, 1'b1, 10'h040, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 3'd1, 1'b1};
    tbl[1]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 1'b1, 10'h012, 1'b1, 1'b0, 10'h000, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{1'b1, 10'h010, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h012, 1'b1, 1'b0, 10'h000, 1'b0, 3'd1, 1'b1};
    tbl[3]  = '{1'b1, 10'h020, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h012, 1'b1, 1'b0, 10'h000, 1'b0, 3'd2, 1'b1};
    tbl[4]  = '{1'b1, 10'h030, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h012, 1'b1, 1'b0, 10'h000, 1'b0, 3'd3, 1'b1};
    tbl[5]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h100, 1'b1, 10'h010, 1'b1, 1'b1, 10'h100, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{1'b1, 10'h050, 1'b0, 10'h000, 1'b1, 1'b1, 10'h100, 1'b0, 10'h010, 1'b1, 1'b0, 10'h100, 1'b0, 3'd0, 1'b0};
    tbl[7]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h100, 1'b0, 10'h010, 1'b1, 1'b0, 10'h100, 1'b0, 3'd0, 1'b1};
    tbl[8]  = '{1'b1, 10'h3FF, 1'b1, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h010, 1'b1, 1'b0, 10'h100, 1'b0, 3'd1, 1'b1};
    tbl[9]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 10'h3FF, 1'b0, 1'b1, 10'h000, 1'b0, 3'd0, 1'b0};
    tbl[10] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 1'b0};
    tbl[11] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 1'b1};
    tbl[12] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h055, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b1, 3'd0, 1'b1};
    tbl[13] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 1'b1};
    tbl[14] = '{1'b1, 10'h100, 1'b1, 10'h200, 1'b0, 1'b0, 10'h000, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 3'd1, 1'b1};
    tbl[15] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h201, 1'b1, 10'h100, 1'b1, 1'b1, 10'h201, 1'b0, 3'd0, 1'b0};
    tbl[16] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h100, 1'b1, 1'b0, 10'h201, 1'b0, 3'd0, 1'b0};
    tbl[17] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h100, 1'b1, 1'b0, 10'h201, 1'b0, 3'd0, 1'b1};
    tbl[18] = '{1'b1, 10'h2AA, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h100, 1'b1, 1'b0, 10'h201, 1'b0, 3'd1, 1'b1};

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    #12;
    chk("reset_upd_we", 32'(upd_we), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_pred_ready", 32'(pred_ready), 32'd1);

    foreach (tbl[i]) begin
      drive(tbl[i].pv, tbl[i].ppc, tbl[i].pt, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
      @(posedge clk); #1;
      chk($sformatf("v%0d_upd_we", i),      32'(upd_we),      32'(tbl[i].we));
      chk($sformatf("v%0d_upd_pc", i),      32'(upd_pc),      32'(tbl[i].upc));
      chk($sformatf("v%0d_upd_taken", i),   32'(upd_taken),   32'(tbl[i].ut));
      chk($sformatf("v%0d_mispredict", i),  32'(mispredict),  32'(tbl[i].mis));
      chk($sformatf("v%0d_redirect_pc", i), 32'(redirect_pc), 32'(tbl[i].rpc));
      chk($sformatf("v%0d_res_err", i),     32'(res_err),     32'(tbl[i].err));
      chk($sformatf("v%0d_count", i),       32'(count),       32'(tbl[i].cnt));
      chk($sformatf("v%0d_pred_ready", i),  32'(pred_ready),  32'(tbl[i].rdy));
    end

    // Asynchronous reset mid-cycle with a non-empty queue and stale outputs.
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_upd_pc", 32'(upd_pc), 32'd0);
    chk("async_rst_upd_taken", 32'(upd_taken), 32'd0);
    chk("async_rst_redirect_pc", 32'(redirect_pc), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Full queue, refused fifth prediction, then resolve+enqueue at count 3.
    for (int i = 0; i < 4; i++) step(1'b1, 10'h0A0 + 10'(i), 1'(i), 10'h1C0 + 10'(i), 1'b0, 1'b0, 10'h000);
    chk("full_count", 32'(count), 32'd4);
    step(1'b1, 10'h0A4, 1'b1, 10'h1C4, 1'b0, 1'b0, 10'h000);
    step_resolve_ok(1'b0, 10'h000);
    step_resolve_ok(1'b1, 10'h0A5);
    chk("simul_count", 32'(count), 32'd3);
    for (int i = 0; i < 6; i++) step_resolve_ok(1'b1, 10'h0A6 + 10'(i));
    chk("fifo_order_last_pc", 32'(upd_pc), 32'h0A8);

    // Underflow in RUN.
    do_reset();
    step(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 1'b1, 10'h033);
    step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic pv, pt, rv, rt;
      logic [9:0] ppc, ptg, rtg;
      pv  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      ppc = 10'($urandom);
      ptg = 10'($urandom_range(0, 3));
      rv  = 1'($urandom_range(0, 1));
      rt  = 1'($urandom_range(0, 1));
      rtg = 10'($urandom_range(0, 3));
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = mq[0].t;
        if (rt) rtg = mq[0].tg;
      end
      step(pv, ppc, pt, ptg, rv, rt, rtg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
